// File: rtl/keypad_matrix_emulator_if.sv
// Key-code handshake between a key source and keypad_matrix_emulator.
// The master offers codes; the slave reports FIFO space through in_ready.
interface keypad_matrix_emulator_if;
  logic       in_valid;
  logic [3:0] in_code;
  logic       in_ready;

  modport master (output in_valid, output in_code, input in_ready);
  modport slave  (input in_valid, input in_code, output in_ready);
endinterface

// File: rtl/keypad_matrix_emulator.sv
// Emulates presses of keys 0-9 on a scanned 4-row x 3-column active-low keypad.
// Optional macro KEYEMU_BOUNCE_EN: the first BOUNCE_ROUNDS press rounds drive only even rounds.
module keypad_matrix_emulator #(
  parameter int DEPTH         = 4,
  parameter int HOLD_ROUNDS   = 3,
  parameter int GAP_ROUNDS    = 2,
  parameter int BOUNCE_ROUNDS = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  keypad_matrix_emulator_if.slave  key_if,
  input  logic [2:0]               sel,
  output logic [2:0]               column,
  output logic                     busy,
  output logic [3:0]               pressed_code,
  output logic                     key_done,
  output logic                     code_err
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [7:0] HOLD_R  = 8'(HOLD_ROUNDS);
  localparam logic [7:0] GAP_R   = 8'(GAP_ROUNDS);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 ||
      HOLD_ROUNDS < 1 || HOLD_ROUNDS > 255 || GAP_ROUNDS < 1 || GAP_ROUNDS > 255 ||
      BOUNCE_ROUNDS < 0 || BOUNCE_ROUNDS > 255) begin : g_param_err
    $error("keypad_matrix_emulator: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, WAIT_SYNC, PRESS, GAP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]  round_cnt_q, round_cnt_d;
  logic [3:0]  pressed_code_q, pressed_code_d;
  logic [2:0]  column_q, column_d;
  logic        key_done_q, key_done_d;
  logic        code_err_q, code_err_d;
  logic [2:0]  sel_q;
  logic        full, empty, bad_code, push, boundary, drive_en;

  // Row index with bit 3 set for "no key", so no sel value can ever match it.
  function automatic logic [3:0] key_row(input logic [3:0] code);
    case (code)
      4'd1, 4'd2, 4'd3: key_row = 4'd0;
      4'd4, 4'd5, 4'd6: key_row = 4'd1;
      4'd7, 4'd8, 4'd9: key_row = 4'd2;
      4'd0:             key_row = 4'd3;
      default:          key_row = 4'b1000;
    endcase
  endfunction

  function automatic logic [2:0] key_col(input logic [3:0] code);
    case (code)
      4'd1, 4'd4, 4'd7:       key_col = 3'b011;
      4'd2, 4'd5, 4'd8, 4'd0: key_col = 3'b101;
      4'd3, 4'd6, 4'd9:       key_col = 3'b110;
      default:                key_col = 3'b111;
    endcase
  endfunction

  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign bad_code = (key_if.in_code > 4'd9);
  assign push     = key_if.in_valid && !full && !bad_code;
  assign boundary = (sel_q == 3'b011) && (sel == 3'b000);

`ifdef KEYEMU_BOUNCE_EN
  localparam logic [7:0] BOUNCE_R = 8'(BOUNCE_ROUNDS);
  assign drive_en = (round_cnt_d >= BOUNCE_R) || !round_cnt_d[0];
`else
  assign drive_en = 1'b1;
`endif

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    round_cnt_d    = round_cnt_q;
    pressed_code_d = pressed_code_q;
    rd_ptr_d       = rd_ptr_q;
    key_done_d     = 1'b0;
    wr_ptr_d       = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    code_err_d     = key_if.in_valid && !full && bad_code;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          pressed_code_d = mem_q[rd_ptr_q[AW-1:0]];
          rd_ptr_d       = rd_ptr_q + PTR_ONE;
          round_cnt_d    = '0;
          state_d        = WAIT_SYNC;
        end
      end
      WAIT_SYNC: begin
        if (boundary) begin
          round_cnt_d = '0;
          state_d     = PRESS;
        end
      end
      PRESS: begin
        if (boundary) begin
          if (round_cnt_q + 8'd1 == HOLD_R) begin
            pressed_code_d = 4'b1111;
            round_cnt_d    = '0;
            state_d        = GAP;
          end else begin
            round_cnt_d = round_cnt_q + 8'd1;
          end
        end
      end
      GAP: begin
        if (boundary) begin
          if (round_cnt_q + 8'd1 == GAP_R) begin
            key_done_d  = 1'b1;
            round_cnt_d = '0;
            state_d     = IDLE;
          end else begin
            round_cnt_d = round_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Decoding from next-cycle state keeps the first and last rounds of a press complete.
    column_d = 3'b111;
    if (state_d == PRESS && drive_en && key_row(pressed_code_d) == {1'b0, sel})
      column_d = key_col(pressed_code_d);
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      round_cnt_q    <= '0;
      pressed_code_q <= 4'b1111;
      column_q       <= 3'b111;
      key_done_q     <= 1'b0;
      code_err_q     <= 1'b0;
      sel_q          <= 3'b000;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      round_cnt_q    <= round_cnt_d;
      pressed_code_q <= pressed_code_d;
      column_q       <= column_d;
      key_done_q     <= key_done_d;
      code_err_q     <= code_err_d;
      sel_q          <= sel;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= key_if.in_code;
  end

  assign key_if.in_ready = !full;
  assign busy            = !empty || (state_q != IDLE);
  assign column          = column_q;
  assign pressed_code    = pressed_code_q;
  assign key_done        = key_done_q;
  assign code_err        = code_err_q;

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Directed bench for keypad_matrix_emulator: a 4-row scanner holds each sel for 4 clk.
// Expected drive counts follow KEYEMU_BOUNCE_EN when it is defined.
`timescale 1ns/1ps
module tb_keypad_matrix_emulator;
  localparam int DEPTH  = 4;
  localparam int HOLD   = 3;
  localparam int GAP    = 2;
  localparam int BOUNCE = 2;
  localparam int ROUND  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] sel = 3'd0;
  logic [2:0] column;
  logic       busy, key_done, code_err;
  logic [3:0] pressed_code;

  int  vectors = 0;
  int  miscompares = 0;
  bit  skip_row3 = 1'b0;
  logic [3:0] sel_cnt = 4'd0;
  logic [3:0] exp_codes[$];

  keypad_matrix_emulator_if kif();

  keypad_matrix_emulator #(
    .DEPTH(DEPTH), .HOLD_ROUNDS(HOLD), .GAP_ROUNDS(GAP), .BOUNCE_ROUNDS(BOUNCE)
  ) dut (
    .clk(clk), .rst(rst), .key_if(kif.slave), .sel(sel), .column(column),
    .busy(busy), .pressed_code(pressed_code), .key_done(key_done), .code_err(code_err)
  );

  always #5 clk = ~clk;

  // Scanner model: rows 0..3, each for 4 clk; optionally never visits row 3.
  initial forever begin
    @(negedge clk);
    if (rst) sel_cnt = 4'd0;
    else     sel_cnt = sel_cnt + 4'd1;
    sel = (skip_row3 && sel_cnt[3:2] == 2'd3) ? 3'd2 : {1'b0, sel_cnt[3:2]};
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] exp_row(input logic [3:0] c);
    case (c)
      4'd1, 4'd2, 4'd3: return 3'd0;
      4'd4, 4'd5, 4'd6: return 3'd1;
      4'd7, 4'd8, 4'd9: return 3'd2;
      4'd0:             return 3'd3;
      default:          return 3'd7;
    endcase
  endfunction

  function automatic logic [2:0] exp_col(input logic [3:0] c);
    case (c)
      4'd1, 4'd4, 4'd7:       return 3'b011;
      4'd2, 4'd5, 4'd8, 4'd0: return 3'b101;
      4'd3, 4'd6, 4'd9:       return 3'b110;
      default:                return 3'b111;
    endcase
  endfunction

  function automatic int exp_drv();
    int n = 0;
    for (int r = 0; r < HOLD; r++) begin
`ifdef KEYEMU_BOUNCE_EN
      if (r >= BOUNCE || r % 2 == 0) n += 4;
`else
      n += 4;
`endif
    end
    return n;
  endfunction

  task automatic push(input logic [3:0] c);
    int n = 0;
    @(negedge clk);
    kif.in_valid = 1'b1;
    kif.in_code  = c;
    while (!kif.in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      vectors++; miscompares++;
      $display("FAIL push_timeout: in_ready=%b after %0d cycles, required 1", kif.in_ready, n);
    end
    @(posedge clk);
    #1 kif.in_valid = 1'b0;
  endtask

  // Follows n keys to completion, checking order, column decode, press length and gap length.
  task automatic observe(input int n_keys);
    int         done_cnt = 0, idx = 0, drv = 0, cyc = 0, rel_cyc = -1;
    logic [3:0] cur = 4'hF;
    logic [2:0] s;
    while (done_cnt < n_keys && cyc < 3000) begin
      @(posedge clk);
      s = sel;
      #1;
      cyc++;
      if (rel_cyc >= 0) rel_cyc++;
      if (pressed_code !== cur) begin
        vectors++;
        if (pressed_code === 4'hF) begin
          if (drv !== exp_drv()) begin
            miscompares++;
            $display("FAIL press_length key %0d: driven cycles=%0d, required %0d", cur, drv, exp_drv());
          end
          rel_cyc = 0;
        end else begin
          if (idx >= exp_codes.size() || pressed_code !== exp_codes[idx]) begin
            miscompares++;
            $display("FAIL key_order #%0d: pressed_code=%0d, required %0d", idx, pressed_code,
                     (idx < exp_codes.size()) ? exp_codes[idx] : 4'hF);
          end
          idx++;
          drv = 0;
        end
        cur = pressed_code;
      end
      if (column !== 3'b111) begin
        drv++;
        vectors++;
        if (s !== exp_row(cur) || column !== exp_col(cur)) begin
          miscompares++;
          $display("FAIL drive key %0d: column=%b at sel=%0d, required %b at sel=%0d",
                   cur, column, s, exp_col(cur), exp_row(cur));
        end
      end
      if (key_done === 1'b1) begin
        vectors++;
        if (rel_cyc !== GAP * ROUND) begin
          miscompares++;
          $display("FAIL gap_length: key_done %0d cycles after release, required %0d", rel_cyc, GAP * ROUND);
        end
        done_cnt++;
        rel_cyc = -1;
      end
    end
    vectors++;
    if (done_cnt !== n_keys || idx !== n_keys) begin
      miscompares++;
      $display("FAIL key_count: key_done=%0d pressed=%0d, required %0d", done_cnt, idx, n_keys);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_keys: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors += 6;
    if (column !== 3'b111)       begin miscompares++; $display("FAIL reset_column: %b, required 111", column); end
    if (pressed_code !== 4'hF)   begin miscompares++; $display("FAIL reset_pressed: %h, required f", pressed_code); end
    if (kif.in_ready !== 1'b1)   begin miscompares++; $display("FAIL reset_in_ready: %b, required 1", kif.in_ready); end
    if (busy !== 1'b0)           begin miscompares++; $display("FAIL reset_busy: %b, required 0", busy); end
    if (key_done !== 1'b0)       begin miscompares++; $display("FAIL reset_key_done: %b, required 0", key_done); end
    if (code_err !== 1'b0)       begin miscompares++; $display("FAIL reset_code_err: %b, required 0", code_err); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_press();
    exp_codes = {4'd5};
    push(4'd5);
    observe(1);
  endtask

  task automatic test_key0_and_9();
    exp_codes = {4'd0};
    push(4'd0);
    observe(1);
    exp_codes = {4'd9};
    push(4'd9);
    observe(1);
  endtask

  task automatic test_invalid_code();
    push(4'd12);
    vectors += 3;
    if (code_err !== 1'b1)     begin miscompares++; $display("FAIL invalid_err_pulse: code_err=%b, required 1", code_err); end
    if (busy !== 1'b0)         begin miscompares++; $display("FAIL invalid_busy: busy=%b, required 0", busy); end
    if (kif.in_ready !== 1'b1) begin miscompares++; $display("FAIL invalid_ready: in_ready=%b, required 1", kif.in_ready); end
    @(posedge clk);
    #1;
    vectors += 2;
    if (code_err !== 1'b0) begin miscompares++; $display("FAIL invalid_err_width: code_err=%b, required 0", code_err); end
    if (busy !== 1'b0)     begin miscompares++; $display("FAIL invalid_no_write: busy=%b, required 0", busy); end
    push(4'd15);
    vectors++;
    if (code_err !== 1'b1) begin miscompares++; $display("FAIL invalid15_err: code_err=%b, required 1", code_err); end
  endtask

  task automatic test_fifo_full();
    exp_codes = {4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7};
    fork
      begin
        push(4'd1); push(4'd2); push(4'd3); push(4'd4); push(4'd6);
        vectors++;
        if (kif.in_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL fifo_full_ready: in_ready=%b, required 0", kif.in_ready);
        end
        push(4'd7);
      end
      observe(6);
    join
  endtask

  task automatic test_back_to_back();
    exp_codes = {4'd3, 4'd3};
    push(4'd3);
    push(4'd3);
    observe(2);
  endtask

  task automatic test_stalled_scan();
    bit drove = 1'b0;
    skip_row3 = 1'b1;
    push(4'd4);
    repeat (5 * ROUND) begin
      @(posedge clk);
      #1;
      if (column !== 3'b111) drove = 1'b1;
    end
    vectors += 3;
    if (drove)                 begin miscompares++; $display("FAIL stall_no_drive: column driven without a boundary, required 111"); end
    if (busy !== 1'b1)         begin miscompares++; $display("FAIL stall_busy: busy=%b, required 1", busy); end
    if (pressed_code !== 4'd4) begin miscompares++; $display("FAIL stall_pressed: %0d, required 4", pressed_code); end
    exp_codes = {4'd4};
    skip_row3 = 1'b0;
    observe(1);
  endtask

  task automatic test_reset_mid_press();
    int  n = 0;
    bit  bad = 1'b0;
    push(4'd8);
    push(4'd2);
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (column === 3'b111 && n < 200);
    vectors++;
    if (column !== 3'b101) begin
      miscompares++;
      $display("FAIL mid_press_start: column=%b, required 101 for key 8", column);
    end
    #2 rst = 1'b1;
    #1;
    vectors += 4;
    if (column !== 3'b111)     begin miscompares++; $display("FAIL async_reset_column: %b, required 111", column); end
    if (busy !== 1'b0)         begin miscompares++; $display("FAIL async_reset_busy: %b, required 0", busy); end
    if (kif.in_ready !== 1'b1) begin miscompares++; $display("FAIL async_reset_ready: %b, required 1", kif.in_ready); end
    if (pressed_code !== 4'hF) begin miscompares++; $display("FAIL async_reset_pressed: %h, required f", pressed_code); end
    @(negedge clk);
    rst = 1'b0;
    repeat (8 * ROUND) begin
      @(posedge clk);
      #1;
      if (column !== 3'b111 || busy !== 1'b0 || key_done !== 1'b0) bad = 1'b1;
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL after_reset_quiet: activity seen after reset, required column 111 busy 0 key_done 0");
    end
  endtask

  initial begin
    kif.in_valid = 1'b0;
    kif.in_code  = 4'd0;
    test_reset();
    test_basic_press();
    test_key0_and_9();
    test_invalid_code();
    test_fifo_full();
    test_back_to_back();
    test_stalled_scan();
    test_reset_mid_press();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_matrix_emulator.md
Name: keypad_matrix_emulator

Overview:
- Drives the 3-column, active-low keypad matrix from the FPGA side. It emulates a human pressing keys 0-9 on the scanned 4-row keypad.
- Key codes are queued through a valid/ready handshake. Each key is then held for a programmed number of complete row-scan rounds, followed by a release gap.
- Used for board loopback and regression of the keypad scanner / key buffer / LED path. Its `column` output feeds the scanner's column input; the scanner's `sel` feeds back into this block.

Parameters:
- DEPTH, 4: key FIFO entries; power of two, 2..16.
- HOLD_ROUNDS, 3: complete scan rounds a key stays pressed; range 1..255.
- GAP_ROUNDS, 2: complete scan rounds of full release between keys; range 1..255.
- BOUNCE_ROUNDS, 2: leading rounds of bounce emulation; only used with KEYEMU_BOUNCE_EN.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: key code offered.
- in_code, input, 4: key code, BCD 0-9.
- in_ready, output, 1: FIFO not full.
- sel, input, 3: row select from the scanner, synchronous to clk. Row 0 = keys 1-3, row 1 = keys 4-6, row 2 = keys 7-9, row 3 = key 0.
- column, output, 3: active-low column drive, registered.
- busy, output, 1: FIFO non-empty or state not IDLE.
- pressed_code, output, 4: code currently held; 4'b1111 when none.
- key_done, output, 1: one-cycle pulse at the end of each key's gap.
- code_err, output, 1: one-cycle pulse when an invalid code (10-15) is accepted.

Behaviour:
- Reset values: column = 3'b111, pressed_code = 4'b1111, in_ready = 1, busy = 0, key_done = 0, code_err = 0. FIFO is emptied, state = IDLE, counters = 0, sel_q = 3'b000.
- Handshake: a transfer occurs on a clk edge with in_valid & in_ready.
  - Codes 0-9 are written to the FIFO.
  - Codes 10-15 are dropped (no FIFO write) and code_err pulses the following cycle.
  - in_ready = !full; it is independent of in_valid.
  - Simultaneous push and pop when full is allowed: the pop frees a slot in the same cycle, but in_ready still reflects the registered full flag.
- Round boundary: sel_q holds sel registered every cycle. A boundary is one cycle where sel_q == 3'b011 and sel == 3'b000.
  - Sel values 4-7 are never boundaries and never drive a column.
  - If sel skips row 3, no boundary occurs and rounds stall.
- State machine:
  - IDLE: if FIFO is non-empty, pop the head, load pressed_code, clear the round counter, go to WAIT_SYNC. The same-cycle pop is allowed.
  - WAIT_SYNC: wait for the next boundary, then go to PRESS with round count 0. This aligns each press to a full round.
  - PRESS: count boundaries. At the HOLD_ROUNDS-th boundary, set pressed_code = 4'b1111 and go to GAP.
  - GAP: count boundaries. At the GAP_ROUNDS-th boundary, pulse key_done and go to IDLE.
- Column drive: registered, one clk of latency from sel.
  - In PRESS, when row(pressed_code) == sel: column = 3'b011 for keys 1/4/7, 3'b101 for keys 2/5/8/0, 3'b110 for keys 3/6/9.
  - Otherwise column = 3'b111.
  - In IDLE, WAIT_SYNC and GAP, column = 3'b111.
- Back-to-back keys: the minimum spacing is HOLD_ROUNDS + GAP_ROUNDS rounds plus alignment. Identical consecutive codes are therefore always separated by a visible release.
- Counter widths: 8 bits; count is compared for equality against the parameter value.
- Reset mid-operation: column returns to 3'b111 immediately (asynchronous). The queued keys are lost.
- FIFO: circular buffer with log2(DEPTH)+1-bit pointers. Full and empty are derived from pointer MSB/LSB comparison. Pointers wrap at DEPTH.

Optional Feature:
- Macro: KEYEMU_BOUNCE_EN.
- Defined: during the first BOUNCE_ROUNDS rounds of PRESS, the column is driven only in even-numbered rounds (0, 2, ...) and held at 3'b111 in odd rounds. The remaining HOLD_ROUNDS - BOUNCE_ROUNDS rounds are driven solidly. If BOUNCE_ROUNDS >= HOLD_ROUNDS, the whole press bounces.
- Not defined: the press is solid for all HOLD_ROUNDS rounds, and the BOUNCE_ROUNDS parameter is ignored.

Test Plan:
- Basic press: reset, sel cycles 0,1,2,3 each held for 4 clk; push code 5.
  - Expect column = 3'b101 only one clk after sel = 1, for exactly 3 rounds.
  - Then 2 rounds at 3'b111, then one key_done pulse; pressed_code goes 5 -> 4'b1111.
- Key 0 mapping: push 0. Expect column = 3'b101 only while delayed sel = 3. Push 9: expect column = 3'b110 at sel = 2.
- FIFO full: DEPTH = 4, push 1, 2, 3, 4, 6, 7 back-to-back while a scan is running.
  - in_ready drops after the FIFO fills.
  - All accepted keys are emitted in order; no key is lost or duplicated.
- Invalid code: push 12. Expect a code_err pulse; no FIFO write; busy stays 0.
- Reset mid-press: assert rst during PRESS of key 8. Expect column = 3'b111 asynchronously; busy = 0, in_ready = 1; after release, no further presses.
- With KEYEMU_BOUNCE_EN and HOLD_ROUNDS = 4, BOUNCE_ROUNDS = 2: key 3.
  - Round 0: column 3'b110. Round 1: released. Rounds 2 and 3: 3'b110.
  - The scanner's key_code latches 3.
